// File: rtl/l1_line_cache.sv
// Direct-mapped, write-back, write-allocate line cache between a CPU port and
// physical memory. Hits complete combinationally; misses go through WRITEBACK/FILL.
module l1_line_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [11:0]  mem_address,
  input  logic [127:0] mem_wdata,
  input  logic [15:0]  mem_sel,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [11:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [1:0]   dbg_state
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_t;

  // Handshake: CPU holds mem_read/mem_write until the single-cycle mem_resp;
  // pmem_read/pmem_write are held by the cache until the single-cycle pmem_resp.

  state_t                state_q, state_d;
  logic [11:0]           addr_q, addr_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d;
  logic [NUM_SETS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [TAG_W-1:0]      tag_d  [NUM_SETS];
  logic [127:0]          data_q [NUM_SETS];
  logic [127:0]          data_d [NUM_SETS];

  logic [IDX_W-1:0]      cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [IDX_W-1:0]      miss_idx;
  logic [TAG_W-1:0]      miss_tag;
  logic                  hit;
  logic                  req;
  logic [127:0]          merged;

  assign cpu_idx   = mem_address[IDX_W-1:0];
  assign cpu_tag   = mem_address[11:IDX_W];
  assign miss_idx  = addr_q[IDX_W-1:0];
  assign miss_tag  = addr_q[11:IDX_W];
  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign req       = mem_read || mem_write;
  assign mem_rdata = data_q[cpu_idx];
  assign dbg_state = state_q;

  always_comb begin
    merged = data_q[cpu_idx];
    for (int i = 0; i < 16; i++) begin
      if (mem_sel[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = mem_address;
    pmem_wdata   = data_q[cpu_idx];

    unique case (state_q)
      ST_IDLE: begin
        if (req && !reset) begin
          addr_d = mem_address;
          if (hit) begin
            mem_resp = 1'b1;
            // Write wins when both strobes are high.
            if (mem_write) begin
              data_d[cpu_idx]  = merged;
              dirty_d[cpu_idx] = 1'b1;
            end
          end else if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx], miss_idx};
        pmem_wdata   = data_q[miss_idx];
        if (pmem_resp) begin
          dirty_d[miss_idx] = 1'b0;
          state_d           = ST_FILL;
        end
      end
      ST_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        pmem_wdata   = data_q[miss_idx];
        if (pmem_resp && !reset) begin
          data_d[miss_idx]  = pmem_rdata;
          tag_d[miss_idx]   = miss_tag;
          valid_d[miss_idx] = 1'b1;
          dirty_d[miss_idx] = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; the _d terms are already gated by reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_l1_line_cache.sv
// Directed bench for l1_line_cache: fills, write hits, dirty eviction,
// request drop, mid-fill reset and simultaneous read/write.
module tb_l1_line_cache;

  logic         clk;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [11:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_sel;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [11:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   dbg_state;

  int pass_cnt;
  int total_cnt;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  localparam logic [127:0] LINE_L  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] LINE_L2 = 128'h00112233_44556677_8899aabb_ccddbeef;
  localparam logic [127:0] LINE_M  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] LINE_N  = 128'h13579bdf_2468ace0_fedcba98_76543210;
  localparam logic [127:0] LINE_W  = 128'hcafebabe_deadbeef_01234567_89abcdef;
  localparam logic [127:0] JUNK    = 128'hffffffff_ffffffff_ffffffff_ffffffff;

  l1_line_cache #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_sel      (mem_sel),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .dbg_state    (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    reset       = 1'b1;
    mem_read    = 1'b1;
    mem_write   = 1'b1;
    mem_address = 12'h040;
    mem_wdata   = '0;
    mem_sel     = 16'hffff;
    pmem_rdata  = '0;
    pmem_resp   = 1'b1;

    // Reset with active-looking inputs: everything must stay quiet.
    tick();
    check("rst_state", 128'(dbg_state), 128'(S_IDLE));
    check("rst_mem_resp", 128'(mem_resp), 128'd0);
    check("rst_pmem_read", 128'(pmem_read), 128'd0);
    check("rst_pmem_write", 128'(pmem_write), 128'd0);
    tick();
    reset     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    #1;
    check("post_rst_mem_resp", 128'(mem_resp), 128'd0);
    check("post_rst_pmem_read", 128'(pmem_read), 128'd0);

    // Cold read 0x040.
    mem_read    = 1'b1;
    mem_address = 12'h040;
    #1;
    check("cold_miss_resp", 128'(mem_resp), 128'd0);
    check("idle_pmem_addr", 128'(pmem_address), 128'h040);
    check("idle_pmem_read", 128'(pmem_read), 128'd0);
    tick();
    check("cold_state_fill", 128'(dbg_state), 128'(S_FILL));
    check("cold_pmem_read", 128'(pmem_read), 128'd1);
    check("cold_pmem_write", 128'(pmem_write), 128'd0);
    check("cold_pmem_addr", 128'(pmem_address), 128'h040);
    tick();
    check("cold_fill_hold", 128'(pmem_read), 128'd1);
    pmem_rdata = LINE_L;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("cold_resp", 128'(mem_resp), 128'd1);
    check("cold_rdata", mem_rdata, LINE_L);
    check("cold_pmem_read_off", 128'(pmem_read), 128'd0);
    mem_read = 1'b0;
    tick();

    // Write hit of bytes 0-1.
    mem_write = 1'b1;
    mem_sel   = 16'h0003;
    mem_wdata = {{14{8'h5a}}, 16'hbeef};
    #1;
    check("wr_hit_resp", 128'(mem_resp), 128'd1);
    tick();
    mem_write = 1'b0;
    #1;
    check("wr_hit_resp_drop", 128'(mem_resp), 128'd0);
    mem_read = 1'b1;
    #1;
    check("rd_after_wr_resp", 128'(mem_resp), 128'd1);
    check("rd_after_wr_data", mem_rdata, LINE_L2);
    tick();

    // Conflict read 0x048 evicts the dirty 0x040 line.
    mem_address = 12'h048;
    #1;
    check("evict_miss_resp", 128'(mem_resp), 128'd0);
    tick();
    check("evict_state_wb", 128'(dbg_state), 128'(S_WB));
    check("wb_pmem_write", 128'(pmem_write), 128'd1);
    check("wb_pmem_read", 128'(pmem_read), 128'd0);
    check("wb_pmem_addr", 128'(pmem_address), 128'h040);
    check("wb_pmem_wdata", pmem_wdata, LINE_L2);
    check("wb_mem_resp", 128'(mem_resp), 128'd0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("evict_fill_read", 128'(pmem_read), 128'd1);
    check("evict_fill_write", 128'(pmem_write), 128'd0);
    check("evict_fill_addr", 128'(pmem_address), 128'h048);
    pmem_rdata = LINE_M;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("evict_resp", 128'(mem_resp), 128'd1);
    check("evict_rdata", mem_rdata, LINE_M);
    mem_read = 1'b0;
    tick();

    // Request dropped during FILL of 0x050.
    mem_read    = 1'b1;
    mem_address = 12'h050;
    tick();
    check("drop_state_fill", 128'(dbg_state), 128'(S_FILL));
    check("drop_pmem_addr", 128'(pmem_address), 128'h050);
    mem_read   = 1'b0;
    pmem_rdata = LINE_N;
    pmem_resp  = 1'b1;
    #1;
    check("drop_no_resp_fill", 128'(mem_resp), 128'd0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("drop_state_idle", 128'(dbg_state), 128'(S_IDLE));
    check("drop_no_resp_idle", 128'(mem_resp), 128'd0);
    tick();
    mem_read = 1'b1;
    #1;
    check("drop_later_hit", 128'(mem_resp), 128'd1);
    check("drop_later_data", mem_rdata, LINE_N);
    mem_read = 1'b0;
    tick();

    // Reset mid-FILL of 0x041 with a stray pmem_resp; no line may be updated.
    mem_read    = 1'b1;
    mem_address = 12'h041;
    tick();
    check("rstfill_pmem_read", 128'(pmem_read), 128'd1);
    reset      = 1'b1;
    pmem_rdata = JUNK;
    pmem_resp  = 1'b1;
    #1;
    check("rstfill_gate_read", 128'(pmem_read), 128'd0);
    tick();
    check("rstfill_read_next", 128'(pmem_read), 128'd0);
    check("rstfill_state", 128'(dbg_state), 128'(S_IDLE));
    reset     = 1'b0;
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    tick();
    mem_read    = 1'b1;
    mem_address = 12'h050;
    #1;
    check("rstfill_old_miss", 128'(mem_resp), 128'd0);
    tick();
    check("rstfill_refill_state", 128'(dbg_state), 128'(S_FILL));
    pmem_rdata = LINE_N;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("refill_resp", 128'(mem_resp), 128'd1);
    mem_read = 1'b0;
    tick();

    // Simultaneous read+write on a hit: full-line write, single response.
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_sel   = 16'hffff;
    mem_wdata = LINE_W;
    #1;
    check("rw_resp", 128'(mem_resp), 128'd1);
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("rw_single_resp", 128'(mem_resp), 128'd0);
    check("rw_line_data", mem_rdata, LINE_W);
    mem_read    = 1'b1;
    mem_address = 12'h058;
    tick();
    check("rw_dirty_wb_state", 128'(dbg_state), 128'(S_WB));
    check("rw_dirty_wb_addr", 128'(pmem_address), 128'h050);
    check("rw_dirty_wb_data", pmem_wdata, LINE_W);
    pmem_resp = 1'b1;
    tick();
    pmem_rdata = LINE_M;
    #1;
    check("rw_fill_state", 128'(dbg_state), 128'(S_FILL));
    tick();
    pmem_resp = 1'b0;
    #1;
    check("rw_final_resp", 128'(mem_resp), 128'd1);
    check("rw_final_data", mem_rdata, LINE_M);
    mem_read = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/l1_line_cache.md
L1_LINE_CACHE -- requirements
Module: l1_line_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, meaning number of direct-mapped lines (power of 2, index = log2(NUM_SETS) bits of line address LSBs, tag = remaining bits of 12).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port mem_read  input  1  CPU-side line read request, held until mem_resp.
REQ-005 SHALL have port mem_write  input  1  CPU-side write request, held until mem_resp.
REQ-006 SHALL have port mem_address  input  12  CPU-side 16-byte line address.
REQ-007 SHALL have port mem_wdata  input  128  CPU-side write line, bytes placed at their line offsets.
REQ-008 SHALL have port mem_sel  input  16  per-byte write enable; bit i enables byte i (bits [8i+7:8i]).
REQ-009 SHALL have port mem_rdata  output  128  line data returned to CPU.
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion strobe for CPU request.
REQ-011 SHALL have port pmem_read  output  1  physical-memory line read request.
REQ-012 SHALL have port pmem_write  output  1  physical-memory line write request.
REQ-013 SHALL have port pmem_address  output  12  physical-memory line address.
REQ-014 SHALL have port pmem_wdata  output  128  line written back to physical memory.
REQ-015 SHALL have port pmem_rdata  input  128  line returned by physical memory.
REQ-016 SHALL have port pmem_resp  input  1  physical-memory completion strobe.

Function
REQ-017 SHALL be a direct-mapped, write-back, write-allocate cache with per-line valid bit, dirty bit, tag and 128-bit data.
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, FILL; reset state IDLE.
REQ-019 Hit SHALL be defined as valid[index] && tag[index]==mem_address tag field, evaluated combinationally in IDLE.
REQ-020 In IDLE with (mem_read||mem_write) and hit, SHALL assert mem_resp combinationally in that same cycle (zero added latency).
REQ-021 mem_rdata SHALL equal data[index] of mem_address at all times (valid to CPU only when mem_resp=1).
REQ-022 Write hit SHALL, at the clock edge of mem_resp, replace bytes of data[index] where mem_sel=1, keep others, and set dirty[index].
REQ-023 mem_read and mem_write both high SHALL be treated as a write.
REQ-024 In IDLE on miss with valid&&dirty[index], SHALL go to WRITEBACK; on miss otherwise, SHALL go to FILL; mem_resp stays 0.
REQ-025 WRITEBACK: pmem_write=1, pmem_address={tag[index],index}, pmem_wdata=data[index]; on pmem_resp SHALL clear dirty[index] and go to FILL.
REQ-026 FILL: pmem_read=1, pmem_address=mem_address; on pmem_resp SHALL load pmem_rdata into data[index], set tag, set valid, clear dirty, go to IDLE.
REQ-027 After FILL, IDLE SHALL re-evaluate; request now hits and completes per REQ-020/022 (miss latency = memory cycles + 1).
REQ-028 If CPU deasserts request during WRITEBACK/FILL, the in-flight transfer SHALL complete normally; no mem_resp is produced.
REQ-029 pmem_read and pmem_write SHALL never be high simultaneously; both SHALL be 0 in IDLE.
REQ-030 pmem_resp in IDLE SHALL be ignored.
REQ-031 In IDLE, pmem_address SHALL equal mem_address and pmem_wdata SHALL equal data[index].
REQ-032 Each CPU request SHALL yield exactly one mem_resp pulse.

Reset
REQ-033 reset high at a clock edge SHALL force state IDLE and clear all valid and dirty bits; tags/data need not be cleared.
REQ-034 While in reset and the cycle after, mem_resp, pmem_read, pmem_write SHALL be 0 regardless of inputs.
REQ-035 reset during WRITEBACK or FILL SHALL abandon the transfer (pmem request drops next cycle) without updating the line.

Verification
REQ-036 Cold read 0x040 -> FILL, pmem_read at 0x040; pmem_resp with line L -> next cycle mem_resp=1, mem_rdata=L.
REQ-037 Write hit 0x040, mem_sel=0x0003, mem_wdata low 16 bits 0xBEEF -> mem_resp same cycle; following read 0x040 returns L with bytes 0-1 = 0xEF,0xBE.
REQ-038 Read 0x048 (same index, NUM_SETS=8) after REQ-037 -> pmem_write at 0x040 with modified line, then pmem_read at 0x048, then mem_resp.
REQ-039 Request drop: read 0x050 miss, deassert mem_read during FILL -> fill completes, no mem_resp; later read 0x050 hits with mem_resp same cycle.
REQ-040 reset asserted mid-FILL -> pmem_read=0 next cycle, read of previously valid address misses.
REQ-041 Simultaneous mem_read=mem_write=1 on hit, mem_sel=0xFFFF -> line replaced by mem_wdata, dirty set, single mem_resp.
